// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch queue: single-outstanding imem fetch FSM feeding a decode FIFO
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [5:0]  dec_opcode,
    output logic [5:0]  dec_func
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    // Only one request is ever in flight and issue requires a free slot,
    // so the entry for the returning word is implicitly reserved at issue.
    always_comb begin
        issue     = (state == IDLE) && (count < DEPTH_C) && !redirect;
        push      = (state == WAIT) && imem_valid && !redirect;
        pop       = (count != '0) && dec_ready && !redirect;
        state_nxt = state;
        unique case (state)
            IDLE: if (issue) state_nxt = WAIT;
            WAIT: begin
                if (imem_valid)    state_nxt = IDLE;
                else if (redirect) state_nxt = DROP;
            end
            DROP: if (imem_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst_b so the strobe drops the moment reset asserts.
    assign imem_req  = issue && rst_b;
    assign imem_addr = imem_req ? fetch_pc : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                count    <= '0;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (issue) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= imem_data;
            pc_mem[tail]   <= req_pc;
        end
    end

    assign dec_valid  = (count != '0);
    assign dec_inst   = dec_valid ? inst_mem[head] : '0;
    assign dec_pc     = dec_valid ? pc_mem[head] : '0;
    assign dec_opcode = dec_inst[31:26];
    assign dec_func   = dec_inst[5:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue against a queue-based reference model
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [5:0]  dec_opcode;
    logic [5:0]  dec_func;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_inst   (dec_inst),
        .dec_pc     (dec_pc),
        .dec_opcode (dec_opcode),
        .dec_func   (dec_func)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference model: decoded-instruction queue plus a record of the one in-flight request.
    ent_t        q[$];
    logic [31:0] m_fetch;
    bit          m_pend;
    bit          m_stale;
    logic [31:0] m_addr;
    int          wait_cnt;
    int          lat_max;

    int          checks = 0;
    int          failures = 0;
    int          req_seen;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h0109_5020;
        return a * 32'h9E37_79B1 + 32'h0000_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fetch  = RESET_PC;
        m_pend   = 0;
        m_stale  = 0;
        m_addr   = '0;
        wait_cnt = 0;
    endtask

    // vmode: 0 = memory model answers, 1 = force imem_valid high, 2 = force low.
    task automatic tick(input bit rd, input logic [31:0] rpc, input bit rdy, input int vmode);
        bit          v;
        logic [31:0] d;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        bit          e_req;
        bit          do_pop;
        ent_t        e;
        if (vmode == 1)      v = 1;
        else if (vmode == 2) v = 0;
        else if (m_pend)     v = (wait_cnt == 0);
        else                 v = ($urandom_range(0, 5) == 0);
        d = m_pend ? mem_word(m_addr) : $urandom;
        if (m_pend && !v && wait_cnt > 0) wait_cnt--;
        redirect    = rd;
        redirect_pc = rpc;
        dec_ready   = rdy;
        imem_valid  = v;
        imem_data   = d;
        #1;
        e_inst = (q.size() != 0) ? q[0].inst : 32'h0;
        e_pc   = (q.size() != 0) ? q[0].pc : 32'h0;
        e_req  = !m_pend && (q.size() < DEPTH) && !rd;
        chk("dec_valid", 32'(dec_valid), 32'(q.size() != 0));
        chk("dec_inst", dec_inst, e_inst);
        chk("dec_pc", dec_pc, e_pc);
        chk("dec_opcode", 32'(dec_opcode), 32'(e_inst[31:26]));
        chk("dec_func", 32'(dec_func), 32'(e_inst[5:0]));
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, e_req ? m_fetch : 32'h0);
        if (imem_req === 1'b1) begin
            req_seen++;
            last_req_addr = imem_addr;
        end
        do_pop = (q.size() != 0) && rdy && !rd;
        if (rd) begin
            q.delete();
            m_fetch = {rpc[31:2], 2'b00};
            if (m_pend) begin
                if (v) m_pend = 0;
                else   m_stale = 1;
            end
        end else begin
            if (do_pop) e = q.pop_front();
            if (m_pend && v) begin
                if (!m_stale) q.push_back('{m_addr, d});
                m_pend = 0;
            end
            if (e_req) begin
                m_pend   = 1;
                m_stale  = 0;
                m_addr   = m_fetch;
                m_fetch  = m_fetch + 32'd4;
                wait_cnt = $urandom_range(0, lat_max);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b       = 1'b0;
        imem_valid  = 1'b0;
        imem_data   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b1;
        lat_max     = 0;
        req_seen    = 0;
        last_req_addr = '0;
        model_reset();

        // Reset state
        @(posedge clk);
        #2;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_inst", dec_inst, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        rst_b = 1'b1;

        // Two-instruction program through a one-cycle memory
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        chk("prog_pc0", dec_pc, 32'h0);
        chk("prog_op0", 32'(dec_opcode), 32'h08);
        chk("prog_fn0", 32'(dec_func), 32'h05);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        chk("prog_pc1", dec_pc, 32'h4);
        chk("prog_op1", 32'(dec_opcode), 32'h00);
        chk("prog_fn1", 32'(dec_func), 32'h20);

        // Fill with decode stalled: exactly DEPTH requests, then one pop frees one
        tick(1, 32'h0, 0, 1);
        req_seen = 0;
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);
        chk("full_req_count", 32'(req_seen), 32'd4);
        chk("full_last_addr", last_req_addr, 32'hC);
        chk("full_head_pc", dec_pc, 32'h0);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        chk("refill_req_count", 32'(req_seen), 32'd5);
        chk("refill_addr", last_req_addr, 32'h10);

        // Push and pop together at count 2, then drain through pointer wrap
        tick(1, 32'h80, 0, 1);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("pushpop_head", dec_pc, 32'h84);
        tick(0, 0, 1, 0);
        chk("pushpop_next", dec_pc, 32'h88);
        for (int i = 0; i < 12; i++) tick(0, 0, 1, 0);

        // Redirect in WAIT: response dropped, refetch at aligned target
        tick(1, 32'h200, 1, 1);
        tick(0, 0, 1, 2);
        tick(1, 32'h103, 1, 2);
        chk("redir_empty", 32'(dec_valid), 32'h0);
        tick(0, 0, 1, 1);
        chk("redir_dropped", 32'(dec_valid), 32'h0);
        tick(0, 0, 1, 2);
        chk("redir_addr", last_req_addr, 32'h100);

        // Redirect coinciding with imem_valid in WAIT
        tick(1, 32'h300, 1, 1);
        tick(0, 0, 1, 2);
        tick(1, 32'h500, 1, 1);
        chk("coinc_nopush", 32'(dec_valid), 32'h0);
        tick(0, 0, 1, 2);
        chk("coinc_addr", last_req_addr, 32'h500);

        // Asynchronous reset mid-WAIT with a non-empty queue
        tick(1, 32'h40, 0, 1);
        for (int i = 0; i < 7; i++) tick(0, 0, 0, 0);
        chk("prereset_valid", 32'(dec_valid), 32'h1);
        rst_b = 1'b0;
        #1;
        chk("arst_imem_req", 32'(imem_req), 32'h0);
        chk("arst_imem_addr", imem_addr, 32'h0);
        chk("arst_dec_valid", 32'(dec_valid), 32'h0);
        chk("arst_dec_inst", dec_inst, 32'h0);
        chk("arst_dec_pc", dec_pc, 32'h0);
        #1;
        rst_b = 1'b1;
        model_reset();
        tick(0, 0, 1, 1);
        chk("arst_first_addr", last_req_addr, RESET_PC);
        tick(0, 0, 1, 2);
        chk("arst_stale_ignored", 32'(dec_valid), 32'h0);

        // Randomized traffic including fetch_pc wrap at 2^32
        lat_max = 3;
        tick(1, 32'hFFFF_FFF4, 1, 1);
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 7, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
